uart_frame_parser: RTL and testbench

//   Consumes the byte stream from the UART receiver (8-bit data plus a one-cycle ready strobe) and extracts framed

---
 rtl/uart_frame_parser.sv | 151 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts SYNC/LEN/payload/CHK frames from a UART byte stream and replays validated payloads
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int         IW   = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int         CW   = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] LMAX = 8'(MAX_LEN);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    rd_q, rd_d;
    logic [7:0]    sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          wr_en;
    logic          timed;
    logic [7:0]    chk;
    logic [7:0]    mem_q [2**IW];

    // State, counters and error flags; mid-frame reset aborts back to HUNT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
            len_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Payload buffer; contents are meaningless until a frame has been written
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx_q[IW-1:0]] <= rx_data;
    end

    // Frame parsing, emit sequencing and inter-byte timeout; a byte on the expiry cycle beats the timeout
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
        chk     = sum_q + rx_data;
        timed   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
        if (timed) cnt_d = rx_valid ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_HUNT: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > LMAX) begin
                        state_d = S_HUNT;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        state_d = S_PAYLOAD;
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        idx_d   = '0;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    wr_en = 1'b1;
                    sum_d = chk;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (chk == 8'd0) begin
                        state_d = S_EMIT;
                        rd_d    = '0;
                    end else begin
                        state_d = S_HUNT;
                        err_d   = 1'b1;
                        code_d  = 2'd0;
                    end
                end
            end
            S_EMIT: begin
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = 2'd3;
                end
                if (out_ready) begin
                    rd_d = rd_q + 8'd1;
                    if (rd_q == len_q - 8'd1) state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase
        if (timed && !rx_valid && cnt_q == TMAX) begin
            state_d = S_HUNT;
            err_d   = 1'b1;
            code_d  = 2'd2;
            cnt_d   = '0;
        end
    end

    // Output stream is driven straight from registered state so reset clears it at once
    always_comb begin
        out_valid = state_q == S_EMIT;
        out_data  = out_valid ? mem_q[rd_q[IW-1:0]] : 8'd0;
        out_last  = out_valid && (rd_q == len_q - 8'd1);
        busy      = state_q != S_HUNT;
        frame_err = err_q;
        err_code  = code_q;
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed frame scenarios for uart_frame_parser
module tb_uart_frame_parser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    logic [7:0] od_q [$];
    logic       ol_q [$];

    uart_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record accepted output bytes and error pulses, sampled mid-cycle
    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) begin
            od_q.push_back(out_data);
            ol_q.push_back(out_last);
        end
        if (frame_err) err_seen++;
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_logs();
        od_q.delete();
        ol_q.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0h expected 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got %0h expected 0", out_data); end
        checks++; if (frame_err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL reset_err got %0h/%0h expected 0/0", frame_err, err_code); end
        checks++; if (busy !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_busy_last got %0h/%0h expected 0/0", busy, out_last); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
        clear_logs();
        out_ready = 1'b1;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL good_pre_chk got valid=%0h busy=%0h expected 0/1", out_valid, busy); end
        send(8'h97);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin failures++; $display("FAIL good_first got valid=%0h data=%0h expected 1/11", out_valid, out_data); end
        idle(6);
        checks++; if (od_q.size() != 3) begin failures++; $display("FAIL good_count got %0d expected 3", od_q.size()); end
        for (int i = 0; i < 3 && i < od_q.size(); i++) begin
            checks++; if (od_q[i] !== exp_d[i] || ol_q[i] !== exp_l[i]) begin failures++; $display("FAIL good_byte%0d got %0h/%0h expected %0h/%0h", i, od_q[i], ol_q[i], exp_d[i], exp_l[i]); end
        end
        checks++; if (err_seen != 0 || busy !== 1'b0) begin failures++; $display("FAIL good_err_busy got %0d/%0h expected 0/0", err_seen, busy); end
    endtask

    task automatic test_bad_len();
        clear_logs();
        send(8'hA5); send(8'h00);
        checks++; if (frame_err !== 1'b1 || err_code !== 2'd1) begin failures++; $display("FAIL len0 got %0h/%0h expected 1/1", frame_err, err_code); end
        idle(1);
        send(8'hA5); send(8'h11);
        checks++; if (frame_err !== 1'b1 || err_code !== 2'd1) begin failures++; $display("FAIL len17 got %0h/%0h expected 1/1", frame_err, err_code); end
        send(8'h00); send(8'h11); send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        idle(4);
        checks++; if (err_seen != 2 || err_code !== 2'd1) begin failures++; $display("FAIL len_pulses got %0d/%0h expected 2/1", err_seen, err_code); end
        checks++; if (od_q.size() != 1) begin failures++; $display("FAIL len_recover_count got %0d expected 1", od_q.size()); end
        else begin
            checks++; if (od_q[0] !== 8'h7F || ol_q[0] !== 1'b1) begin failures++; $display("FAIL len_recover_byte got %0h/%0h expected 7f/1", od_q[0], ol_q[0]); end
        end
    endtask

    task automatic test_bad_chk();
        clear_logs();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
        checks++; if (frame_err !== 1'b1 || err_code !== 2'd0) begin failures++; $display("FAIL chk_pulse got %0h/%0h expected 1/0", frame_err, err_code); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL chk_busy got %0h expected 0", busy); end
        idle(4);
        checks++; if (err_seen != 1 || od_q.size() != 0) begin failures++; $display("FAIL chk_totals got err=%0d out=%0d expected 1/0", err_seen, od_q.size()); end
    endtask

    task automatic test_timeout();
        clear_logs();
        send(8'hA5); send(8'h02); send(8'h10);
        idle(19);
        checks++; if (frame_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_early got %0h/%0h expected 0/1", frame_err, busy); end
        idle(1);
        checks++; if (frame_err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin failures++; $display("FAIL to_expire got %0h/%0h/%0h expected 1/2/0", frame_err, err_code, busy); end
        idle(2);
        clear_logs();
        send(8'hA5); send(8'h02); send(8'h10);
        idle(19);
        send(8'h20); send(8'hCE);
        checks++; if (frame_err !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL to_edge got err=%0h valid=%0h expected 0/1", frame_err, out_valid); end
        idle(4);
        checks++; if (err_seen != 0 || od_q.size() != 2) begin failures++; $display("FAIL to_edge_totals got err=%0d out=%0d expected 0/2", err_seen, od_q.size()); end
        else begin
            checks++; if (od_q[0] !== 8'h10 || od_q[1] !== 8'h20 || ol_q[1] !== 1'b1) begin failures++; $display("FAIL to_edge_bytes got %0h %0h last=%0h expected 10 20 1", od_q[0], od_q[1], ol_q[1]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        out_ready = 1'b0;
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hB8);
        send(8'hA5); send(8'h01); send(8'h02);
        idle(2);
        checks++; if (err_seen != 3 || err_code !== 2'd3) begin failures++; $display("FAIL ovr_pulses got %0d/%0h expected 3/3", err_seen, err_code); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h12 || out_last !== 1'b0) begin failures++; $display("FAIL ovr_stall got %0h/%0h/%0h expected 1/12/0", out_valid, out_data, out_last); end
        out_ready = 1'b1;
        idle(4);
        checks++; if (od_q.size() != 2) begin failures++; $display("FAIL ovr_count got %0d expected 2", od_q.size()); end
        else begin
            checks++; if (od_q[0] !== 8'h12 || od_q[1] !== 8'h34 || ol_q[0] !== 1'b0 || ol_q[1] !== 1'b1) begin failures++; $display("FAIL ovr_bytes got %0h %0h expected 12 34", od_q[0], od_q[1]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_busy got %0h expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        send(8'hA5); send(8'h03); send(8'h01);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || err_code !== 2'd0 || frame_err !== 1'b0) begin failures++; $display("FAIL rst_payload got %0h/%0h/%0h expected 0/0/0", busy, err_code, frame_err); end
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h55); send(8'hAA);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin failures++; $display("FAIL rst_emit_pre got %0h/%0h expected 1/55", out_valid, out_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'd0 || out_last !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_emit got %0h/%0h/%0h/%0h expected 0/0/0/0", out_valid, out_data, out_last, busy); end
        @(negedge clk) rst_n = 1'b1;
        clear_logs();
        out_ready = 1'b1;
        send(8'hA5); send(8'h01); send(8'h55); send(8'hAA);
        idle(3);
        checks++; if (od_q.size() != 1 || err_seen != 0) begin failures++; $display("FAIL rst_after got out=%0d err=%0d expected 1/0", od_q.size(), err_seen); end
        else begin
            checks++; if (od_q[0] !== 8'h55 || ol_q[0] !== 1'b1) begin failures++; $display("FAIL rst_after_byte got %0h/%0h expected 55/1", od_q[0], ol_q[0]); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_len();
        test_bad_chk();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
